// File: rtl/mac_vec_acc.sv
// mac_vec_acc: multi-lane dot-product multiply-accumulate with handshakes.
//
// Each job accumulates 'len' beats. Every beat carries 'lanes' A/B operand
// pairs. When the last beat has been added, one result is presented on
// out/overflow and held until the consumer accepts it.
//
// Ports:
//   clk       clock, rising edge
//   reset     synchronous active-low reset
//   format    0 = two's complement, 1 = sign-magnitude (taken from first beat)
//   sat_en    1 = saturate, 0 = wrap (two's complement only; first beat)
//   len       beats per job (0 behaves as 1; taken from first beat)
//   in_valid  beat valid
//   in_ready  block can accept a beat
//   A, B      packed lane operands, lane i = X[i*bw +: bw]
//   out_valid result valid
//   out_ready consumer accepts result
//   out       result in the job's format
//   overflow  set if any accumulate step of the job clamped or wrapped
module mac_vec_acc #(
  parameter int bw      = 8,
  parameter int psum_bw = 16,
  parameter int lanes   = 4,
  parameter int len_bw  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  format,
  input  logic                  sat_en,
  input  logic [len_bw-1:0]     len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [lanes*bw-1:0]   A,
  input  logic [lanes*bw-1:0]   B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [psum_bw-1:0]    out,
  output logic                  overflow
);

  localparam int DOT_W  = 2*bw + $clog2(lanes);
  localparam int STEP_W = psum_bw + DOT_W;

  localparam logic signed [STEP_W-1:0] TC_MAX = STEP_W'({1'b0, {(psum_bw-1){1'b1}}});
  localparam logic signed [STEP_W-1:0] TC_MIN = -TC_MAX - STEP_W'(1);
  // Sign-magnitude range is symmetric: there is no code for -2^(psum_bw-1).
  localparam logic signed [STEP_W-1:0] SM_MIN = -TC_MAX;

  localparam logic [len_bw-1:0] ONE = len_bw'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic signed [bw-1:0] sm_to_tc(input logic [bw-1:0] x);
    logic signed [bw-1:0] m;
    m = {1'b0, x[bw-2:0]};
    return x[bw-1] ? -m : m;
  endfunction

  function automatic logic [psum_bw-1:0] tc_to_sm(input logic signed [psum_bw-1:0] x);
    logic signed [psum_bw-1:0] m;
    m = x[psum_bw-1] ? -x : x;
    return {x[psum_bw-1], m[psum_bw-2:0]};
  endfunction

  function automatic logic signed [DOT_W-1:0] lane_dot(
    input logic [lanes*bw-1:0] a,
    input logic [lanes*bw-1:0] b,
    input logic                fmt
  );
    logic signed [DOT_W-1:0]  acc;
    logic signed [bw-1:0]     ai;
    logic signed [bw-1:0]     bi;
    logic signed [2*bw-1:0]   ae;
    logic signed [2*bw-1:0]   be;
    acc = '0;
    for (int i = 0; i < lanes; i++) begin
      ai = a[i*bw +: bw];
      bi = b[i*bw +: bw];
      if (fmt) begin
        ai = sm_to_tc(a[i*bw +: bw]);
        bi = sm_to_tc(b[i*bw +: bw]);
      end
      ae  = (2*bw)'(ai);
      be  = (2*bw)'(bi);
      acc = acc + DOT_W'(ae * be);
    end
    return acc;
  endfunction

  // Returns {overflow, new_psum}.
  function automatic logic [psum_bw:0] acc_step(
    input logic signed [psum_bw-1:0] ps,
    input logic signed [DOT_W-1:0]   d,
    input logic                      fmt,
    input logic                      sat
  );
    logic signed [STEP_W-1:0] s;
    logic [psum_bw-1:0]       v;
    logic                     o;
    s = STEP_W'(ps) + STEP_W'(d);
    v = s[psum_bw-1:0];
    o = 1'b0;
    if (fmt) begin
      if (s > TC_MAX) begin
        v = TC_MAX[psum_bw-1:0];
        o = 1'b1;
      end else if (s < SM_MIN) begin
        v = SM_MIN[psum_bw-1:0];
        o = 1'b1;
      end
    end else if (s > TC_MAX || s < TC_MIN) begin
      o = 1'b1;
      if (sat) begin
        v = (s > TC_MAX) ? TC_MAX[psum_bw-1:0] : TC_MIN[psum_bw-1:0];
      end
    end
    return {o, v};
  endfunction

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [len_bw-1:0]           r_cnt;
  logic [len_bw-1:0]           r_len;
  logic                        r_fmt;
  logic                        r_sat;
  logic [lanes*bw-1:0]         r_a_p0;
  logic [lanes*bw-1:0]         r_b_p0;
  logic                        r_vld_p0;
  logic signed [psum_bw-1:0]   r_psum;
  logic                        r_ovf;

  logic                        w_accept;
  logic [len_bw-1:0]           w_len_eff;
  logic [len_bw-1:0]           w_cnt_inc;
  logic signed [DOT_W-1:0]     w_dot_p1;
  logic [psum_bw:0]            w_step_p1;

  assign w_len_eff = (len == '0) ? ONE : len;
  assign w_cnt_inc = r_cnt + ONE;
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = (w_len_eff == ONE) ? S_DRAIN : S_ACC;
      end
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid && (w_cnt_inc == r_len)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage p1: dot product of the registered beat plus the accumulate step.
  assign w_dot_p1  = lane_dot(r_a_p0, r_b_p0, r_fmt);
  assign w_step_p1 = acc_step(r_psum, w_dot_p1, r_fmt, r_sat);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_len    <= '0;
      r_fmt    <= 1'b0;
      r_sat    <= 1'b0;
      r_a_p0   <= '0;
      r_b_p0   <= '0;
      r_vld_p0 <= 1'b0;
      r_psum   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      // Stage p0: operand capture.
      r_vld_p0 <= w_accept;
      if (w_accept) begin
        r_a_p0 <= A;
        r_b_p0 <= B;
      end
      // A first beat is only accepted in IDLE, where no add is pending,
      // so clearing the sum cannot collide with an accumulate.
      if (w_accept && r_state == S_IDLE) begin
        r_fmt  <= format;
        r_sat  <= sat_en;
        r_len  <= w_len_eff;
        r_cnt  <= ONE;
        r_psum <= '0;
        r_ovf  <= 1'b0;
      end else begin
        if (w_accept) r_cnt <= w_cnt_inc;
        if (r_vld_p0) begin
          r_psum <= w_step_p1[psum_bw-1:0];
          r_ovf  <= r_ovf | w_step_p1[psum_bw];
        end
      end
    end
  end

  assign out      = r_fmt ? tc_to_sm(r_psum) : r_psum;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_mac_vec_acc.sv
module tb_mac_vec_acc;

  logic        clk = 1'b0;
  logic        reset;
  logic        format;
  logic        sat_en;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        overflow;

  mac_vec_acc #(.bw(8), .psum_bw(16), .lanes(4), .len_bw(8)) dut (
    .clk(clk), .reset(reset), .format(format), .sat_en(sat_en), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] o;
    logic        ov;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack(input logic [7:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic push(input logic [15:0] o, input logic ov, input string nm);
    exp_t e;
    e.o = o; e.ov = ov; e.nm = nm;
    q.push_back(e);
  endtask

  // Presents one beat and returns one cycle after it was accepted.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic f, input logic s, input logic [7:0] l);
    int t;
    A = a; B = b; format = f; sat_en = s; len = l; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed %0b, expected 1", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while (!out_valid && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: out_valid stayed %0b, expected 1", nm, out_valid);
    end else begin
      step();
    end
  endtask

  // Scoreboard monitor: a result transfers on the edge after this sample.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_out: got out=%0h with empty queue, expected no result", out);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.nm, "_out"}, 32'(out), 32'(e.o));
        chk({e.nm, "_ovf"}, 32'(overflow), 32'(e.ov));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int t;
    reset = 1'b0; format = 1'b0; sat_en = 1'b0; len = 8'd1;
    in_valid = 1'b0; A = '0; B = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out", 32'(out), 0);
    chk("rst_ovf", 32'(overflow), 0);
    reset = 1'b1;
    step();

    // Single beat, latency k+2.
    push(16'h0046, 1'b0, "t1");
    send(pack(1, 2, 3, 4), pack(5, 6, 7, 8), 1'b0, 1'b0, 8'd1);
    chk("t1_valid_k1", 32'(out_valid), 0);
    chk("t1_ready_k1", 32'(in_ready), 0);
    step();
    chk("t1_valid_k2", 32'(out_valid), 1);
    step();
    chk("t1_valid_after", 32'(out_valid), 0);
    chk("t1_ready_after", 32'(in_ready), 1);

    // Three beats with a bubble, then backpressure in DONE.
    out_ready = 1'b0;
    push(16'hFF70, 1'b0, "t2");
    send(pack(8'hFD, 8'hFD, 8'hFD, 8'hFD), pack(4, 4, 4, 4), 1'b0, 1'b0, 8'd3);
    send(pack(8'hFD, 8'hFD, 8'hFD, 8'hFD), pack(4, 4, 4, 4), 1'b0, 1'b0, 8'd3);
    step();
    send(pack(8'hFD, 8'hFD, 8'hFD, 8'hFD), pack(4, 4, 4, 4), 1'b0, 1'b0, 8'd3);
    chk("t2_drain_ready", 32'(in_ready), 0);
    chk("t2_drain_valid", 32'(out_valid), 0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_ready", 32'(in_ready), 0);
      chk("bp_out", 32'(out), 32'h0000FF70);
      chk("bp_ovf", 32'(overflow), 0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_valid_after", 32'(out_valid), 0);
    chk("bp_ready_after", 32'(in_ready), 1);

    // Overflow: saturate then wrap.
    push(16'h7FFF, 1'b1, "t3_sat");
    for (int i = 0; i < 4; i++)
      send(pack(127, 127, 127, 127), pack(127, 127, 127, 127), 1'b0, 1'b1, 8'd4);
    wait_done("t3_sat");
    push(16'hF010, 1'b1, "t3_wrap");
    for (int i = 0; i < 4; i++)
      send(pack(127, 127, 127, 127), pack(127, 127, 127, 127), 1'b0, 1'b0, 8'd4);
    wait_done("t3_wrap");

    // Sign-magnitude, including negative zero operand.
    push(16'h800F, 1'b0, "t4_neg");
    send(pack(8'h83, 0, 0, 0), pack(8'h05, 0, 0, 0), 1'b1, 1'b0, 8'd1);
    wait_done("t4_neg");
    push(16'h0000, 1'b0, "t4_zero");
    send(pack(8'h80, 0, 0, 0), pack(8'h85, 0, 0, 0), 1'b1, 1'b0, 8'd1);
    wait_done("t4_zero");

    // Sign-magnitude saturation to the symmetric negative bound.
    push(16'hFFFF, 1'b1, "t4_sat");
    for (int i = 0; i < 3; i++)
      send(pack(8'hFF, 8'hFF, 8'hFF, 8'hFF), pack(127, 127, 127, 127), 1'b1, 1'b0, 8'd3);
    wait_done("t4_sat");

    // len=0 behaves as a single-beat job.
    push(16'h0018, 1'b0, "t5_len0");
    send(pack(2, 2, 2, 2), pack(3, 3, 3, 3), 1'b0, 1'b0, 8'd0);
    chk("t5_len0_drain", 32'(in_ready), 0);
    wait_done("t5_len0");

    // Reset in the middle of a job.
    send(pack(1, 1, 1, 1), pack(1, 1, 1, 1), 1'b0, 1'b0, 8'd4);
    send(pack(1, 1, 1, 1), pack(1, 1, 1, 1), 1'b0, 1'b0, 8'd4);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_ready", 32'(in_ready), 1);
    chk("mrst_out", 32'(out), 0);
    push(16'h000A, 1'b0, "t6_after_rst");
    send(pack(1, 2, 3, 4), pack(1, 1, 1, 1), 1'b0, 1'b0, 8'd1);
    wait_done("t6_after_rst");

    t = 0;
    while (q.size() != 0 && t < 100) begin
      step();
      t++;
    end
    if (q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_queue: %0d results outstanding, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_vec_acc.md
Name: mac_vec_acc

Overview:
Multi-lane dot-product MAC with valid/ready handshakes on input and output. It is the parametrised successor of the single-lane 2's-complement/sign-magnitude MAC. Each job accumulates a programmable number of vector beats and presents one result; the result is held until the consumer accepts it. The block sits between the operand feeder and the psum writeback path.

Parameters:
bw, 8, operand width per lane (MSB is the sign bit in both formats)
psum_bw, 16, result width
lanes, 4, number of parallel A*B lanes per beat
len_bw, 8, width of the job-length field

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset; sampled on rising clk
format  input  1  0 = 2's complement, 1 = sign-magnitude; sampled with the first beat of a job
sat_en  input  1  1 = saturate, 0 = wrap (format 0 only); sampled with the first beat
len  input  len_bw  number of beats in the job; sampled with the first beat; 0 is treated as 1
in_valid  input  1  beat valid
in_ready  output  1  block accepts a beat
A  input  lanes*bw  lane i = A[i*bw +: bw]
B  input  lanes*bw  lane i = B[i*bw +: bw]
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out  output  psum_bw  result, encoded in the job's format
overflow  output  1  sticky per job: set if any accumulate step clamped or wrapped; valid with out_valid

Behaviour:
- Reset (reset==0 at a rising edge): state IDLE; psum, operand registers, beat counter and overflow cleared; out_valid=0; out=0; in_ready=1 from the next cycle. Reset mid-job discards all pending beats and the partial sum.
- States and in_ready:
  - IDLE: in_ready=1.
  - ACC: in_ready=1.
  - DRAIN: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- Beat acceptance: a beat is accepted on a cycle where in_valid && in_ready.
- IDLE: an accepted beat latches format, sat_en and len (0 becomes 1), clears psum and overflow, and sets count=1. Next state is ACC, or DRAIN if len==1.
- ACC: each accepted beat increments count. When count reaches len, next state is DRAIN. in_valid low in ACC inserts bubbles with no effect.
- Pipeline:
  - Edge ending acceptance cycle k: A and B are registered into a_q/b_q, with a per-stage valid bit.
  - Cycle k+1: the lane dot product is formed combinationally from a_q/b_q and added to psum at the edge ending k+1.
  - Back-to-back beats are accepted every cycle.
- DRAIN lasts exactly 1 cycle. out_valid rises in cycle k+2 after the last beat's acceptance cycle k.
- DONE: out and overflow are held stable while out_valid && !out_ready. On out_ready, the next state is IDLE, out_valid deasserts the next cycle, and in_ready=1 the next cycle. No new beat is accepted in the cycle the result leaves.
- Arithmetic, format 0:
  - Each lane product is signed 2*bw; lane products are summed at full width.
  - The step sum psum+dot is computed at psum_bw+2*bw+clog2(lanes) bits.
  - If the step sum is outside [-2^(psum_bw-1), 2^(psum_bw-1)-1]: with sat_en=1, clamp to the nearest bound; with sat_en=0, truncate to psum_bw bits. In either case set overflow.
- Arithmetic, format 1:
  - Operand value = (-1)^msb * magnitude[bw-2:0]. 8'h80 (-0) equals 0.
  - Accumulation is exact signed arithmetic.
  - The result always saturates to ±(2^(psum_bw-1)-1); sat_en is ignored. Saturation sets overflow.
  - out = {sign, magnitude}. A zero result is always +0 (all bits 0).
- out is driven from the accumulator register only; it is combinationally independent of A/B.

Test Plan:
- Single beat, format 0, len=1, A lanes={1,2,3,4}, B lanes={5,6,7,8}, accepted in cycle k -> out_valid=1 in cycle k+2; out=70 (16'h0046); overflow=0.
- Format 0, len=3, every lane A=-3 and B=4 on each beat, one idle cycle between beats 2 and 3 -> out=-144 (16'hFF70); in_ready=0 from DRAIN until the result is accepted.
- Format 0, len=4, all lanes A=127 and B=127: with sat_en=1 -> out=16'h7FFF, overflow=1; with sat_en=0 -> out=16'hF010, overflow=1.
- Format 1, len=1, lane0 A=8'h83 and B=8'h05, other lanes 0 -> out=16'h800F. Then a second job with lane0 A=8'h80 and B=8'h85 -> out=16'h0000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out, overflow and out_valid are stable and in_ready=0 throughout. Raise out_ready -> the next cycle has out_valid=0 and in_ready=1.
- Drive reset=0 for one edge after the 2nd beat of a len=4 job -> the next cycle has out_valid=0, in_ready=1 and out=0. A new len=1 job then yields only its own dot product.
